mem_arbiter: RTL

- Shares one single-port unified memory between two requesters: instruction fetch (read-only) and the load/store path (read/write).
- Sits between the fetch/data_memory consumers and the physical memory macro.
- Serialises accesses with a 4-state FSM, a fixed-latency wait counter and per-requester grant/response handshakes.
- All outputs are registered.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Used by mem_arbiter and mem_arb_pick; MEM_ARB_RR_EN selects the round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on conflicts; otherwise data has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_d_req,
`ifdef MEM_ARB_RR_EN
    input  logic i_last_winner,
`endif
    output logic o_valid,
    output logic o_win
);

    always_comb begin
        o_valid = i_if_req | i_d_req;
        o_win   = i_d_req ? REQ_D : REQ_IF;
`ifdef MEM_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        if (i_if_req && i_d_req) begin
            o_win = ~i_last_winner;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port memory; all outputs registered.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_win;
    logic               r_we;
    logic               w_pick_valid;
    logic               w_pick_win;
    logic               w_pick_we;

    logic               r_if_gnt;
    logic               r_if_rvalid;
    logic [DATA_W-1:0]  r_if_rdata;
    logic               r_d_gnt;
    logic               r_d_rvalid;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_busy;

`ifdef MEM_ARB_RR_EN
    logic               r_last_winner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_winner <= REQ_D;
        end else if (r_state == ST_ISSUE) begin
            r_last_winner <= r_win;
        end
    end
`endif

    mem_arb_pick u_pick (
        .i_if_req      (if_req),
        .i_d_req       (d_req),
`ifdef MEM_ARB_RR_EN
        .i_last_winner (r_last_winner),
`endif
        .o_valid       (w_pick_valid),
        .o_win         (w_pick_win)
    );

    // Fetch is read-only, so only a data winner can produce a write.
    assign w_pick_we = (w_pick_win == REQ_D) & d_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (r_cnt == '0) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_win       <= REQ_IF;
            r_we        <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_gnt     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= (w_state_next != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_win      <= w_pick_win;
                        r_we       <= w_pick_we;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_we;
                        r_mem_addr <= (w_pick_win == REQ_D) ? d_addr : if_addr;
                        if (w_pick_win == REQ_D) begin
                            r_mem_wdata <= d_wdata;
                        end
                        r_if_gnt   <= (w_pick_win == REQ_IF);
                        r_d_gnt    <= (w_pick_win == REQ_D);
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= LAT_W'(MEM_LAT - 1);
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        // Response registers update only here, so rdata holds elsewhere.
                        if (r_win == REQ_D) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_we ? '0 : mem_rdata;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule
